// File: rtl/weight_sram_arbiter.sv
// Round-robin arbiter sharing the single Weight SRAM read port among the PUs.
// Define WSRAM_ARB_REUSE_EN to enable the one-entry read-reuse tag.
`ifndef PU_NUM
`define PU_NUM 4
`endif

module weight_sram_arbiter #(
    parameter int unsigned NUM_REQ = `PU_NUM,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    localparam int unsigned ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req_read,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_address,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic [DATA_W-1:0]           rd_data,
    output logic [ID_W-1:0]             grant_id,
    output logic                        busy,
    output logic [ADDR_W-1:0]           sram_addr,
    output logic                        sram_r_en,
    input  logic [DATA_W-1:0]           sram_r_d,
    input  logic                        sram_d_ready,
    input  logic                        sram_w_en
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [ID_W-1:0]     last_grant;
    logic [ID_W-1:0]     last_grant_next;
    logic [ID_W-1:0]     grant_id_next;
    logic [ADDR_W-1:0]   sram_addr_next;
    logic                sram_r_en_next;
    logic [NUM_REQ-1:0]  req_ready_next;
    logic [DATA_W-1:0]   rd_data_next;

    logic                found;
    logic [ID_W-1:0]     pick;
    logic [ADDR_W-1:0]   pick_addr;
    logic                hit;
    int unsigned         idx;

    logic [ADDR_W-1:0]   addr_arr [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_addr
        assign addr_arr[gi] = req_address[gi*ADDR_W +: ADDR_W];
    end

    // First requester at or after last_grant+1, wrapping modulo NUM_REQ.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = (32'(last_grant) + 32'd1 + i) % NUM_REQ;
            if (!found && req_read[ID_W'(idx)]) begin
                found = 1'b1;
                pick  = ID_W'(idx);
            end
        end
        pick_addr = addr_arr[pick];
    end

`ifdef WSRAM_ARB_REUSE_EN
    logic                tag_valid;
    logic [ADDR_W-1:0]   tag_addr;

    // Tag tracks the address behind rd_data; any SRAM write invalidates it.
    always_ff @(posedge clock) begin
        if (reset || sram_w_en) begin
            tag_valid <= 1'b0;
            tag_addr  <= tag_addr;
        end else if (state == REQ && sram_d_ready) begin
            tag_valid <= 1'b1;
            tag_addr  <= sram_addr;
        end
    end

    assign hit = tag_valid && (pick_addr == tag_addr);
`else
    assign hit = 1'b0;
`endif

    // Next-state and next-output decode.
    always_comb begin
        state_next      = state;
        last_grant_next = last_grant;
        grant_id_next   = grant_id;
        sram_addr_next  = sram_addr;
        sram_r_en_next  = 1'b0;
        req_ready_next  = '0;
        rd_data_next    = rd_data;
        case (state)
            IDLE: begin
                if (!sram_w_en && found) begin
                    grant_id_next  = pick;
                    sram_addr_next = pick_addr;
                    if (hit) begin
                        state_next     = RESP;
                        req_ready_next = NUM_REQ'(1) << pick;
                    end else begin
                        state_next     = REQ;
                        sram_r_en_next = 1'b1;
                    end
                end
            end
            REQ: begin
                sram_r_en_next = 1'b1;
                if (sram_d_ready) begin
                    rd_data_next    = sram_r_d;
                    sram_r_en_next  = 1'b0;
                    last_grant_next = grant_id;
                    req_ready_next  = NUM_REQ'(1) << grant_id;
                    state_next      = RESP;
                end
            end
            RESP: begin
                last_grant_next = grant_id;
                state_next      = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= ID_W'(NUM_REQ - 1);
            grant_id   <= '0;
            sram_addr  <= '0;
            sram_r_en  <= 1'b0;
            req_ready  <= '0;
            rd_data    <= '0;
            busy       <= 1'b0;
        end else begin
            state      <= state_next;
            last_grant <= last_grant_next;
            grant_id   <= grant_id_next;
            sram_addr  <= sram_addr_next;
            sram_r_en  <= sram_r_en_next;
            req_ready  <= req_ready_next;
            rd_data    <= rd_data_next;
            busy       <= (state_next != IDLE);
        end
    end

endmodule

// File: doc/weight_sram_arbiter.md
Name: weight_sram_arbiter

Overview:
- Arbitrates the single shared Weight SRAM read port among the `PU_NUM` processing units.
- Each PU raises a level read request with its own address. The arbiter grants one PU in round-robin order and drives the Weight SRAM controller read handshake.
- Read data is returned on one shared bus, together with a one-cycle ready pulse to the winning PU only.
- Sits between the PUs' WB_SRAM_read/WB_SRAM_address/WB_SRAM_ready ports and the Weight SRAM controller, replacing ad-hoc muxing in the Delta controller.

Parameters:
- NUM_REQ, default `PU_NUM` (4): number of requesters.
- ADDR_W, default 32: SRAM word address width.
- DATA_W, default 32: SRAM data width.

Ports:
- clock  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- req_read  in  NUM_REQ  per-PU read request (level).
- req_address  in  NUM_REQ*ADDR_W  per-PU address; PU i occupies bits [i*ADDR_W +: ADDR_W].
- req_ready  out  NUM_REQ  one-hot, one-cycle data-valid pulse to the granted PU.
- rd_data  out  DATA_W  registered read data, broadcast to all PUs.
- grant_id  out  clog2(NUM_REQ)  index of the current or most recent grant.
- busy  out  1  high when the FSM is not in IDLE.
- sram_addr  out  ADDR_W  address to the Weight SRAM controller.
- sram_r_en  out  1  read enable to the Weight SRAM controller.
- sram_r_d  in  DATA_W  read data from the Weight SRAM controller.
- sram_d_ready  in  1  read data valid from the Weight SRAM controller.
- sram_w_en  in  1  Weight SRAM write (DRAM load) in progress; blocks new grants.

Behaviour:
- Clock and reset: one clock (clock). Reset (reset) is synchronous and active-high.
- Reset values: req_ready=0, rd_data=0, grant_id=0, busy=0, sram_addr=0, sram_r_en=0. FSM goes to IDLE. last_grant=NUM_REQ-1, so the first grant after reset goes to PU 0.
- FSM states: IDLE, REQ, RESP.
- IDLE:
  - If sram_w_en=0 and any req_read bit is set, grant the first set bit searching upward from last_grant+1, with modulo-NUM_REQ wrap.
  - On a grant: latch req_address[grant] into sram_addr, set grant_id, then go to REQ.
  - Otherwise stay in IDLE.
- REQ:
  - sram_r_en=1; sram_addr is held stable.
  - When sram_d_ready=1: capture sram_r_d into rd_data, set sram_r_en=0, set last_grant=grant_id, go to RESP.
  - sram_w_en has no effect in REQ.
- RESP:
  - req_ready[grant_id]=1 for exactly this cycle; all other req_ready bits are 0.
  - Next state is IDLE unconditionally.
- Request sampling and latency:
  - Requests are sampled only in IDLE.
  - The PU drops or changes req_read at the edge on which it observes req_ready, so the following IDLE cycle sees its updated request.
  - Minimum latency from a request sampled in IDLE to req_ready is 2 cycles, plus SRAM wait cycles. Peak rate is one read per 3 cycles.
- rd_data holds its value until the next capture.
- sram_r_en is never 1 while in IDLE or RESP.
- Requester behaviour while ungranted: a req_read that deasserts before being granted is simply not serviced, with no error. A requester changing its address while ungranted is legal; the value latched in IDLE is used.
- Reset during REQ or RESP: aborts the transaction. No req_ready pulse is issued, and sram_r_en=0 on the next cycle. A late sram_d_ready arriving in IDLE is ignored.
- busy=1 in REQ and RESP.

Optional Feature:
- Macro: WSRAM_ARB_REUSE_EN.
- When defined, the arbiter keeps a one-entry tag (tag_valid, tag_addr = address of the last captured rd_data).
  - In IDLE, if tag_valid=1 and the granted address equals tag_addr, it skips REQ and goes straight to RESP. rd_data is unchanged and no sram_r_en is asserted; latency is 1 cycle.
  - tag_valid is set on each capture in REQ. It is cleared on reset and in any cycle with sram_w_en=1.
  - Round-robin last_grant still updates, in RESP for the hit.
- When undefined: no tag logic; every grant goes through REQ.

Test Plan:
- Single read: after reset, req_read=4'b0100 with address 0x40; sram_d_ready=1 with sram_r_d=0xDEADBEEF in the first REQ cycle -> sram_r_en high for 1 cycle with sram_addr=0x40; req_ready=4'b0100 for one cycle; rd_data=0xDEADBEEF; grant_id=2.
- Simultaneous requests: all four req_read asserted at once after reset, each PU dropping its request on its own ready -> grant order 0,1,2,3, each with 3-cycle spacing when d_ready is immediate.
- Fairness: PU0 and PU3 requesting continuously -> grants alternate 0,3,0,3 and never starve either PU.
- Write blocking: sram_w_en=1 for 10 cycles while req_read[1]=1 -> sram_r_en stays 0 throughout; the grant to PU1 happens in the first IDLE cycle after sram_w_en falls.
- Reset mid-transaction: reset in the second REQ cycle (d_ready still low) -> sram_r_en=0 and busy=0 next cycle; no req_ready; a late d_ready is ignored; the next grant goes to PU0.
- Reuse: PU1 reads 0x80, then PU2 reads 0x80. With WSRAM_ARB_REUSE_EN -> only one sram_r_en, and PU2 sees ready 1 cycle after sampling with the same data; a sram_w_en pulse between the two reads forces a second SRAM read. Without the macro -> two SRAM reads.
